// File: rtl/arb_pkg.sv
// Shared types and constants for the 3-way round-robin arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [1:0] SEL_D0   = 2'd0;
    localparam logic [1:0] SEL_D1   = 2'd1;
    localparam logic [1:0] SEL_D2   = 2'd2;
    localparam logic [1:0] SEL_NONE = 2'd3;

    localparam int MAX_HOLD_DEF = 4;

    // First set request searched cyclically from ptr+1; ptr itself is checked last.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] c;
        case (ptr)
            2'd0:    begin a = SEL_D1; b = SEL_D2; c = SEL_D0; end
            2'd1:    begin a = SEL_D2; b = SEL_D0; c = SEL_D1; end
            default: begin a = SEL_D0; b = SEL_D1; c = SEL_D2; end
        endcase
        if (req[a])      rr_pick = a;
        else if (req[b]) rr_pick = b;
        else if (req[c]) rr_pick = c;
        else             rr_pick = SEL_NONE;
    endfunction

    // Encoded select to one-hot grant; SEL_NONE maps to no grant.
    function automatic logic [2:0] sel_to_onehot(input logic [1:0] sel);
        case (sel)
            SEL_D0:  sel_to_onehot = 3'b001;
            SEL_D1:  sel_to_onehot = 3'b010;
            SEL_D2:  sel_to_onehot = 3'b100;
            default: sel_to_onehot = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/mux31.sv
// 3:1 32-bit payload mux; select 3 yields zero.
// Latency: combinational, zero cycles.
// Backpressure: none, pure datapath.
module mux31
    import arb_pkg::*;
(
    input  logic [1:0]  i_sel,
    input  logic [31:0] i_d0,
    input  logic [31:0] i_d1,
    input  logic [31:0] i_d2,
    output logic [31:0] o_y
);

    // Steer the selected payload, zero when nothing is granted.
    always_comb begin
        case (i_sel)
            SEL_D0:  o_y = i_d0;
            SEL_D1:  o_y = i_d1;
            SEL_D2:  o_y = i_d2;
            default: o_y = 32'd0;
        endcase
    end

endmodule

// File: rtl/rr_arb3.sv
// Round-robin arbiter over 3 requesters with a per-grant transfer cap of MAX_HOLD.
// Latency: 1 cycle request-to-grant; payload y follows select combinationally.
// Backpressure: out_ready=0 stalls the current grant; count and grant hold until transfers resume.
module rr_arb3
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [31:0] d0,
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    input  logic        out_ready,
    output logic [2:0]  grant,
    output logic [1:0]  select,
    output logic [31:0] y,
    output logic        out_valid
);

    state_t      r_state;
    state_t      w_nxt_state;
    logic [2:0]  r_grant;
    logic [2:0]  w_nxt_grant;
    logic [1:0]  r_sel;
    logic [1:0]  w_nxt_sel;
    logic [1:0]  r_ptr;
    logic [1:0]  w_nxt_ptr;
    logic [3:0]  r_cnt;
    logic [3:0]  w_nxt_cnt;
    logic [1:0]  w_pick;
    logic        w_req_g;
    logic        w_xfer;
    logic        w_release;

    // State and grant registers; reset leaves the pointer at 2 so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= 3'b000;
            r_sel   <= SEL_NONE;
            r_ptr   <= SEL_D2;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_nxt_state;
            r_grant <= w_nxt_grant;
            r_sel   <= w_nxt_sel;
            r_ptr   <= w_nxt_ptr;
            r_cnt   <= w_nxt_cnt;
        end
    end

    // Next grant: pick a new winner from IDLE or on release, otherwise hold and count transfers.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_grant = r_grant;
        w_nxt_sel   = r_sel;
        w_nxt_ptr   = r_ptr;
        w_nxt_cnt   = r_cnt;
        w_pick      = rr_pick(req, r_ptr);
        case (r_state)
            IDLE: begin
                w_nxt_cnt = 4'd0;
                if (w_pick != SEL_NONE) begin
                    w_nxt_state = GRANT;
                    w_nxt_sel   = w_pick;
                    w_nxt_grant = sel_to_onehot(w_pick);
                    w_nxt_ptr   = w_pick;
                end
            end
            default: begin
                if (w_release) begin
                    w_nxt_cnt = 4'd0;
                    if (w_pick != SEL_NONE) begin
                        w_nxt_sel   = w_pick;
                        w_nxt_grant = sel_to_onehot(w_pick);
                        w_nxt_ptr   = w_pick;
                    end else begin
                        w_nxt_state = IDLE;
                        w_nxt_sel   = SEL_NONE;
                        w_nxt_grant = 3'b000;
                    end
                end else if (w_xfer) begin
                    w_nxt_cnt = r_cnt + 4'd1;
                end
            end
        endcase
    end

    // Outputs and handshake: valid tracks the granted requester's live request.
    always_comb begin
        w_req_g   = (r_sel == SEL_NONE) ? 1'b0 : req[r_sel];
        out_valid = w_req_g && (r_state == GRANT);
        w_xfer    = out_valid && out_ready;
        w_release = (r_state == GRANT) &&
                    (!w_req_g || (w_xfer && (r_cnt == 4'(MAX_HOLD - 1))));
        grant     = r_grant;
        select    = r_sel;
    end

    mux31 u_mux (
        .i_sel (r_sel),
        .i_d0  (d0),
        .i_d1  (d1),
        .i_d2  (d2),
        .o_y   (y)
    );

endmodule

// File: tb/tb_rr_arb3.sv
// Self-checking bench for rr_arb3: per-cycle scoreboard plus directed scenario checks.
// Latency: expectations for each edge are queued when inputs are driven, compared 1ns after the edge.
// Backpressure: out_ready is driven both held and randomised.
module tb_rr_arb3;

    localparam int MH = 4;

    typedef struct {
        logic [2:0]  grant;
        logic [1:0]  sel;
        logic [31:0] y;
        logic        ov;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [31:0] d0 = 32'd0;
    logic [31:0] d1 = 32'd0;
    logic [31:0] d2 = 32'd0;
    logic        out_ready = 1'b0;
    logic [2:0]  grant;
    logic [1:0]  select;
    logic [31:0] y;
    logic        out_valid;

    int n_asrt = 0;
    int n_fail = 0;

    exp_t sb[$];

    // reference model state
    bit m_busy = 1'b0;
    int m_g    = -1;
    int m_cnt  = 0;
    int m_ptr  = 2;

    rr_arb3 #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .out_ready (out_ready),
        .grant     (grant),
        .select    (select),
        .y         (y),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [2:0] rq, input int p);
        for (int off = 1; off <= 3; off++) begin
            int c;
            c = (p + off) % 3;
            if (rq[c]) return c;
        end
        return -1;
    endfunction

    // Advance the model across one clock edge using the inputs now on the pins.
    task automatic model_edge();
        int n;
        bit v;
        bit x;
        if (reset) begin
            m_busy = 1'b0; m_g = -1; m_cnt = 0; m_ptr = 2;
        end else if (!m_busy) begin
            n = pick(req, m_ptr);
            if (n >= 0) begin
                m_busy = 1'b1; m_g = n; m_ptr = n; m_cnt = 0;
            end
        end else begin
            v = req[m_g];
            x = v && out_ready;
            if (!v || (x && m_cnt == MH - 1)) begin
                n = pick(req, m_g);
                if (n >= 0) begin
                    m_g = n; m_ptr = n; m_cnt = 0;
                end else begin
                    m_busy = 1'b0; m_g = -1; m_cnt = 0;
                end
            end else if (x) begin
                m_cnt++;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.grant = m_busy ? (3'b001 << m_g) : 3'b000;
        e.sel   = m_busy ? 2'(m_g) : 2'd3;
        case (e.sel)
            2'd0:    e.y = d0;
            2'd1:    e.y = d1;
            2'd2:    e.y = d2;
            default: e.y = 32'd0;
        endcase
        e.ov = m_busy && req[m_g];
        return e;
    endfunction

    task automatic step(input logic rst, input logic [2:0] rq, input logic ordy);
        exp_t e;
        @(negedge clk);
        reset     = rst;
        req       = rq;
        out_ready = ordy;
        model_edge();
        sb.push_back(model_out());
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("sb_grant",  32'(grant),     32'(e.grant));
        chk("sb_select", 32'(select),    32'(e.sel));
        chk("sb_y",      y,              e.y);
        chk("sb_valid",  32'(out_valid), 32'(e.ov));
    endtask

    initial begin
        logic [2:0] eg;

        // reset state
        d0 = 32'd100; d1 = 32'd11; d2 = 32'd2;
        step(1'b1, 3'b000, 1'b0);
        step(1'b1, 3'b000, 1'b0);
        chk("rst_grant",  32'(grant),     32'h0);
        chk("rst_select", 32'(select),    32'h3);
        chk("rst_valid",  32'(out_valid), 32'h0);
        chk("rst_y",      y,              32'h0);

        // single requester, 1-cycle grant latency
        step(1'b0, 3'b001, 1'b1);
        chk("first_grant",  32'(grant),     32'h1);
        chk("first_select", 32'(select),    32'h0);
        chk("first_y",      y,              32'd100);
        chk("first_valid",  32'(out_valid), 32'h1);
        step(1'b0, 3'b000, 1'b1);
        chk("drop_idle", 32'(select), 32'h3);

        // all requesting: 0,1,2,0,... four transfers each, no bubbles
        step(1'b1, 3'b000, 1'b0);
        for (int k = 1; k <= 24; k++) begin
            step(1'b0, 3'b111, 1'b1);
            eg = 3'b001 << (((k - 1) / 4) % 3);
            chk("rr_seq",    32'(grant),     32'(eg));
            chk("no_bubble", 32'(out_valid), 32'h1);
        end

        // stall holds grant and count, then four transfers move the grant
        step(1'b1, 3'b000, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 3'b011, 1'b0);
            chk("stall_grant", 32'(grant), 32'h1);
        end
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 3'b011, 1'b1);
            chk("unstall_grant", 32'(grant), (k < 4) ? 32'h1 : 32'h2);
        end

        // lone requester 2 re-granted after MAX_HOLD, count restarts
        step(1'b1, 3'b000, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, 3'b100, 1'b1);
            chk("regrant", 32'(grant), 32'h4);
            chk("regrant_y", y, 32'd2);
        end

        // requester 1 drops after 2 transfers, requester 0 waiting
        step(1'b1, 3'b000, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 3'b010, 1'b1);
        step(1'b0, 3'b001, 1'b1);
        chk("drop_to_0", 32'(grant), 32'h1);
        // requester 1 drops with no one else -> idle
        step(1'b1, 3'b000, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 3'b010, 1'b1);
        step(1'b0, 3'b000, 1'b1);
        chk("drop_idle_sel", 32'(select), 32'h3);
        chk("drop_idle_y",   y,           32'h0);

        // reset mid-grant aborts, then re-arbitration from pointer 2
        step(1'b1, 3'b000, 1'b0);
        step(1'b0, 3'b010, 1'b1);
        step(1'b0, 3'b010, 1'b1);
        step(1'b1, 3'b010, 1'b1);
        chk("rst_mid_grant", 32'(grant),     32'h0);
        chk("rst_mid_valid", 32'(out_valid), 32'h0);
        step(1'b0, 3'b010, 1'b1);
        chk("post_rst_1", 32'(grant), 32'h2);
        step(1'b1, 3'b011, 1'b1);
        step(1'b0, 3'b011, 1'b1);
        chk("post_rst_0", 32'(grant), 32'h1);

        // random traffic against the model
        for (int k = 0; k < 400; k++) begin
            d0 = $urandom; d1 = $urandom; d2 = $urandom;
            step(($urandom_range(0, 39) == 0), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
